// File: rtl/logistic_mult_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals for the shared-multiplier
// arbiter.
//   slave  : arbiter view (takes requests and mult_done/mult_result, drives
//            grant, response and multiplier controls)
//   master : environment view (requesters plus multiplier)
interface logistic_mult_arbiter_if #(
  parameter int unsigned NUM_REQ = 7,
  parameter int unsigned W       = 18
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*W-1:0] dataa_in;
  logic [NUM_REQ*W-1:0] datab_in;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [2*W-1:0]       result;
  logic                 busy;
  logic                 timeout_err;
  logic [W-1:0]         mult_dataa;
  logic [W-1:0]         mult_datab;
  logic                 mult_start;
  logic                 mult_done;
  logic [2*W-1:0]       mult_result;

  modport slave (
    input  req, dataa_in, datab_in, mult_done, mult_result,
    output grant, resp_valid, result, busy, timeout_err,
           mult_dataa, mult_datab, mult_start
  );

  modport master (
    output req, dataa_in, datab_in, mult_done, mult_result,
    input  grant, resp_valid, result, busy, timeout_err,
           mult_dataa, mult_datab, mult_start
  );
endinterface

// File: rtl/logistic_mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ
// logistic-map iterators. Drives the multiplier through a four-phase
// start/done handshake and returns the product with a one-cycle resp_valid.
// Ports:
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : logistic_mult_arbiter_if.slave (requests, operands, grant,
//              resp_valid, result, busy, timeout_err, multiplier handshake)
module logistic_mult_arbiter #(
  parameter int unsigned NUM_REQ = 7,
  parameter int unsigned W       = 18,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  logistic_mult_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_RELEASE, S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]      ptr, ptr_nxt;
  logic [PW-1:0]      gnt_idx, gnt_idx_nxt;
  logic [PW-1:0]      sel_idx;
  logic               sel_vld;
  int unsigned        scan_j;
  logic [CW-1:0]      wdog, wdog_nxt;
  logic               wdog_exp;

  logic [NUM_REQ-1:0] grant_q, grant_nxt;
  logic [NUM_REQ-1:0] resp_q, resp_nxt;
  logic [2*W-1:0]     result_q, result_nxt;
  logic               busy_q, busy_nxt;
  logic               err_q, err_nxt;
  logic [W-1:0]       da_q, da_nxt;
  logic [W-1:0]       db_q, db_nxt;
  logic               start_q, start_nxt;

  assign wdog_exp = (wdog == CW'(TIMEOUT - 1));

  // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo NUM_REQ
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    scan_j  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      scan_j = 32'(ptr) + off;
      if (scan_j >= NUM_REQ) scan_j = scan_j - NUM_REQ;
      if (!sel_vld && bus.req[PW'(scan_j)]) begin
        sel_vld = 1'b1;
        sel_idx = PW'(scan_j);
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (!bus.mult_done && sel_vld) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_WAIT;
      S_WAIT:    if (bus.mult_done)       state_nxt = S_RELEASE;
                 else if (wdog_exp)       state_nxt = S_RESP;
      S_RELEASE: if (!bus.mult_done || wdog_exp) state_nxt = S_RESP;
      S_RESP:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs and datapath state
  always_comb begin
    grant_nxt   = grant_q;
    resp_nxt    = '0;
    result_nxt  = result_q;
    err_nxt     = err_q;
    da_nxt      = da_q;
    db_nxt      = db_q;
    start_nxt   = start_q;
    ptr_nxt     = ptr;
    gnt_idx_nxt = gnt_idx;
    wdog_nxt    = wdog;
    busy_nxt    = (state_nxt != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (!bus.mult_done && sel_vld) begin
          grant_nxt   = NUM_REQ'(1) << sel_idx;
          gnt_idx_nxt = sel_idx;
          da_nxt      = bus.dataa_in[32'(sel_idx)*W +: W];
          db_nxt      = bus.datab_in[32'(sel_idx)*W +: W];
        end
      end
      S_LOAD: begin
        start_nxt = 1'b1;
        wdog_nxt  = '0;
      end
      S_WAIT, S_RELEASE: begin
        wdog_nxt = wdog + CW'(1);
        if (state == S_WAIT && bus.mult_done) begin
          result_nxt = bus.mult_result;
          start_nxt  = 1'b0;
        end else if (state == S_RELEASE && !bus.mult_done) begin
          resp_nxt = grant_q;
        end else if (wdog_exp) begin
          // Watchdog abort: drop start, flag the error, answer with zero
          err_nxt    = 1'b1;
          start_nxt  = 1'b0;
          result_nxt = '0;
          resp_nxt   = grant_q;
        end
      end
      S_RESP: begin
        grant_nxt = '0;
        ptr_nxt   = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_q  <= '0;
      resp_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      da_q     <= '0;
      db_q     <= '0;
      start_q  <= 1'b0;
      ptr      <= '0;
      gnt_idx  <= '0;
      wdog     <= '0;
    end else begin
      grant_q  <= grant_nxt;
      resp_q   <= resp_nxt;
      result_q <= result_nxt;
      busy_q   <= busy_nxt;
      err_q    <= err_nxt;
      da_q     <= da_nxt;
      db_q     <= db_nxt;
      start_q  <= start_nxt;
      ptr      <= ptr_nxt;
      gnt_idx  <= gnt_idx_nxt;
      wdog     <= wdog_nxt;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.resp_valid  = resp_q;
  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;
  assign bus.mult_dataa  = da_q;
  assign bus.mult_datab  = db_q;
  assign bus.mult_start  = start_q;

endmodule

// File: tb/tb_logistic_mult_arbiter.sv
// Directed testbench for logistic_mult_arbiter with a behavioural sequential
// multiplier (done k cycles after start, drops one cycle after start falls,
// optional stuck-low or held-high done).
module tb_logistic_mult_arbiter;

  localparam int unsigned NR = 7;
  localparam int unsigned W  = 18;

  logic CLK;
  logic RST;

  logistic_mult_arbiter_if #(.NUM_REQ(NR), .W(W)) bus ();

  logistic_mult_arbiter #(.NUM_REQ(NR), .W(W), .TIMEOUT(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  int mult_k = 3;
  logic stuck = 1'b0;
  logic hold  = 1'b0;
  int mcnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Multiplier model
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcnt          <= 0;
      bus.mult_done <= 1'b0;
    end else if (!bus.mult_start) begin
      mcnt <= 0;
      if (!hold) bus.mult_done <= 1'b0;
    end else if (!stuck) begin
      if (mcnt == mult_k - 1) bus.mult_done <= 1'b1;
      mcnt <= mcnt + 1;
    end
  end

  assign bus.mult_result = bus.mult_done ?
    (36'(bus.mult_dataa) * 36'(bus.mult_datab)) : 36'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic wait_grant();
    int n;
    n = 0;
    while (bus.grant == '0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (bus.resp_valid == '0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  int n;
  logic [6:0] exp_g;
  logic seen_resp;

  initial begin
    RST = 1'b1;
    bus.req = 7'h7F;
    for (int i = 0; i < 7; i++) begin
      bus.dataa_in[i*18 +: 18] = 18'(i + 1);
      bus.datab_in[i*18 +: 18] = 18'(256 * (i + 1));
    end
    tick(); tick();

    // 1. reset state with all requests pending
    chk("rst_grant",  64'(bus.grant), 64'h0);
    chk("rst_resp",   64'(bus.resp_valid), 64'h0);
    chk("rst_result", 64'(bus.result), 64'h0);
    chk("rst_busy",   64'(bus.busy), 64'h0);
    chk("rst_err",    64'(bus.timeout_err), 64'h0);
    chk("rst_start",  64'(bus.mult_start), 64'h0);
    chk("rst_dataa",  64'(bus.mult_dataa), 64'h0);
    RST = 1'b0;
    tick();

    // 3. continuous requests: 0,1,...,6,0 with one idle cycle between services
    for (int s = 0; s < 8; s++) begin
      exp_g = 7'(1 << (s % 7));
      chk("rr_grant", 64'(bus.grant), 64'(exp_g));
      chk("rr_busy",  64'(bus.busy), 64'h1);
      chk("rr_dataa", 64'(bus.mult_dataa), 64'((s % 7) + 1));
      wait_resp(n);
      chk("rr_latency", 64'(n), 64'd7);
      chk("rr_resp",    64'(bus.resp_valid), 64'(exp_g));
      chk("rr_result",  64'(bus.result), 64'(((s % 7) + 1) * ((s % 7) + 1) * 256));
      if (s == 7) bus.req = 7'h00;
      tick();
      chk("rr_idle_grant", 64'(bus.grant), 64'h0);
      chk("rr_resp_pulse", 64'(bus.resp_valid), 64'h0);
      chk("rr_idle_busy",  64'(bus.busy), 64'h0);
      if (s < 7) tick();
    end

    // 2. single request, operands and req changed after the grant edge
    bus.dataa_in[2*18 +: 18] = 18'h10000;
    bus.datab_in[2*18 +: 18] = 18'h08000;
    bus.req = 7'h04;
    wait_grant();
    chk("single_grant", 64'(bus.grant), 64'h04);
    chk("single_dataa", 64'(bus.mult_dataa), 64'h10000);
    chk("single_datab", 64'(bus.mult_datab), 64'h08000);
    bus.req = 7'h00;
    bus.dataa_in[2*18 +: 18] = 18'h3FFFF;
    wait_resp(n);
    chk("single_latency", 64'(n), 64'd7);
    chk("single_resp",    64'(bus.resp_valid), 64'h04);
    chk("single_result",  64'(bus.result), 64'h0_8000_0000);
    tick();

    // 4. serve 3, then req=09 -> 0 first (pointer wraps), then 3
    bus.req = 7'h08;
    wait_grant();
    chk("wrap_g3", 64'(bus.grant), 64'h08);
    wait_resp(n);
    chk("wrap_r3", 64'(bus.resp_valid), 64'h08);
    bus.req = 7'h09;
    tick();
    tick();
    chk("wrap_g0", 64'(bus.grant), 64'h01);
    wait_resp(n);
    chk("wrap_r0", 64'(bus.resp_valid), 64'h01);
    tick();
    tick();
    chk("wrap_g3b", 64'(bus.grant), 64'h08);
    wait_resp(n);
    bus.req = 7'h00;
    tick();

    // 5. done stuck low -> watchdog abort, then normal service
    stuck = 1'b1;
    bus.req = 7'h02;
    wait_grant();
    chk("wd_grant", 64'(bus.grant), 64'h02);
    bus.req = 7'h00;
    wait_resp(n);
    chk("wd_latency", 64'(n), 64'd17);
    chk("wd_resp",    64'(bus.resp_valid), 64'h02);
    chk("wd_err",     64'(bus.timeout_err), 64'h1);
    chk("wd_result",  64'(bus.result), 64'h0);
    chk("wd_start",   64'(bus.mult_start), 64'h0);
    stuck = 1'b0;
    tick();
    bus.req = 7'h20;
    wait_grant();
    chk("wd_next_grant", 64'(bus.grant), 64'h20);
    bus.req = 7'h00;
    wait_resp(n);
    chk("wd_next_latency", 64'(n), 64'd7);
    chk("wd_next_result",  64'(bus.result), 64'h2400);
    chk("wd_err_sticky",   64'(bus.timeout_err), 64'h1);
    tick();

    // 5b. done held high -> abort in RELEASE, IDLE blocks until done drops
    hold = 1'b1;
    bus.req = 7'h01;
    wait_grant();
    chk("hold_grant", 64'(bus.grant), 64'h01);
    bus.req = 7'h40;
    wait_resp(n);
    chk("hold_latency", 64'(n), 64'd17);
    chk("hold_result",  64'(bus.result), 64'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("hold_block", 64'(bus.grant), 64'h0);
    end
    hold = 1'b0;
    wait_grant();
    chk("hold_release_grant", 64'(bus.grant), 64'h40);
    bus.req = 7'h00;
    wait_resp(n);
    chk("hold_release_result", 64'(bus.result), 64'h3100);
    tick();

    // 6. reset during WAIT; pending request re-served from pointer 0
    bus.req = 7'h02;
    wait_grant();
    bus.req = 7'h00;
    wait_resp(n);
    tick();
    bus.req = 7'h21;
    wait_grant();
    chk("rstw_grant", 64'(bus.grant), 64'h20);
    tick();
    chk("rstw_start", 64'(bus.mult_start), 64'h1);
    RST = 1'b1;
    #1;
    chk("rstw_start_drop", 64'(bus.mult_start), 64'h0);
    chk("rstw_grant_drop", 64'(bus.grant), 64'h0);
    chk("rstw_busy_drop",  64'(bus.busy), 64'h0);
    seen_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.resp_valid != '0) seen_resp = 1'b1;
    end
    RST = 1'b0;
    tick();
    if (bus.resp_valid != '0) seen_resp = 1'b1;
    chk("rstw_no_resp",  64'(seen_resp), 64'h0);
    chk("rstw_regrant",  64'(bus.grant), 64'h01);
    wait_resp(n);
    chk("rstw_resp",     64'(bus.resp_valid), 64'h01);
    chk("rstw_result",   64'(bus.result), 64'h100);
    bus.req = 7'h00;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
